// File: rtl/led_glow_if.sv
// Configuration handshake bundle for led_glow_sched.
// The master offers a sweep; the slave accepts it when idle.
interface led_glow_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [5:0] cfg_start;
  logic [5:0] cfg_end;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_start,
    output cfg_end,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_start,
    input  cfg_end,
    output cfg_ready
  );
endinterface

// File: rtl/led_glow_sched.sv
// Glow sequencer: ramps one LED at a time up and down with a
// 16-level first-order PWM, stepping across a channel range.
module led_glow_sched #(
  parameter int NOUT     = 55,
  parameter int STEP_DIV = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  led_glow_if.slave       cfg,
  input  logic            abort,
  output logic [NOUT:0]   out,
  output logic            busy,
  output logic [5:0]      active_idx,
  output logic            sweep_done,
  output logic            cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    ADVANCE
  } state_t;

  localparam int         NW   = NOUT + 1;
  localparam logic [5:0] NMAX = 6'(NOUT);

  state_t                state;
  logic [1:0]            mode_q;
  logic [5:0]            start_q;
  logic [5:0]            end_q;
  logic                  dir_q;
  logic [3:0]            level;
  logic [STEP_DIV-1:0]   presc;
  logic [4:0]            acc;

  logic                  tick;
  logic                  cfg_bad;
  logic [5:0]            idx_step;
  logic [4:0]            acc_nxt;
  logic [NOUT:0]         pwm_vec;

  assign tick     = &presc;
  assign cfg_bad  = (cfg.cfg_start > NMAX) ||
                    (cfg.cfg_end > NMAX);
  // dir_q=1 walks downward through the channel range
  assign idx_step = dir_q ? active_idx - 6'd1
                          : active_idx + 6'd1;
  assign acc_nxt  = {1'b0, acc[3:0]} + {1'b0, level};
  assign pwm_vec  = NW'(acc[4]) << active_idx;

  assign busy          = (state != IDLE);
  assign cfg.cfg_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      start_q    <= 6'd0;
      end_q      <= 6'd0;
      dir_q      <= 1'b0;
      level      <= 4'd0;
      presc      <= '0;
      acc        <= 5'd0;
      out        <= '0;
      active_idx <= 6'd0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
      out        <= '0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        level <= 4'd0;
        presc <= '0;
        acc   <= 5'd0;
      end else begin
        unique case (state)
          IDLE: begin
            presc <= '0;
            acc   <= 5'd0;
            if (cfg.cfg_valid) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else if (cfg.cfg_mode != 2'd0) begin
                mode_q     <= cfg.cfg_mode;
                start_q    <= cfg.cfg_start;
                end_q      <= cfg.cfg_end;
                dir_q      <= cfg.cfg_start > cfg.cfg_end;
                active_idx <= cfg.cfg_start;
                level      <= 4'd0;
                state      <= RAMP_UP;
              end
            end
          end
          RAMP_UP: begin
            presc <= presc + STEP_DIV'(1);
            acc   <= acc_nxt;
            out   <= pwm_vec;
            if (tick) begin
              if (level == 4'hF) state <= RAMP_DOWN;
              else               level <= level + 4'd1;
            end
          end
          RAMP_DOWN: begin
            presc <= presc + STEP_DIV'(1);
            acc   <= acc_nxt;
            if (tick && level == 4'd0) begin
              state <= ADVANCE;
            end else begin
              out <= pwm_vec;
              if (tick) level <= level - 4'd1;
            end
          end
          ADVANCE: begin
            presc <= '0;
            acc   <= 5'd0;
            level <= 4'd0;
            state <= RAMP_UP;
            if (active_idx != end_q) begin
              active_idx <= idx_step;
            end else begin
              sweep_done <= 1'b1;
              case (mode_q)
                2'd1: state <= IDLE;
                2'd2: active_idx <= start_q;
                default: begin
                  start_q <= end_q;
                  end_q   <= start_q;
                  dir_q   <= ~dir_q;
                  // step along the reversed direction
                  if (start_q != end_q)
                    active_idx <= dir_q ? active_idx + 6'd1
                                        : active_idx - 6'd1;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_glow_sched.sv
// Directed bench for led_glow_sched with STEP_DIV=2
// (129 cycles per channel, 60 PWM highs per channel).
module tb_led_glow_sched;
  localparam int NOUT = 55;

  logic          clk;
  logic          rst_n;
  logic          abort;
  logic [NOUT:0] out;
  logic          busy;
  logic [5:0]    active_idx;
  logic          sweep_done;
  logic          cfg_err;

  led_glow_if cif ();

  led_glow_sched #(
    .NOUT     (NOUT),
    .STEP_DIV (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cif),
    .abort      (abort),
    .out        (out),
    .busy       (busy),
    .active_idx (active_idx),
    .sweep_done (sweep_done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_seq [8];
  bit done_after [8];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m,
                       input logic [5:0] s,
                       input logic [5:0] e);
    cif.cfg_mode  = m;
    cif.cfg_start = s;
    cif.cfg_end   = e;
    cif.cfg_valid = 1'b1;
    step();
    cif.cfg_valid = 1'b0;
  endtask

  // Follows nch channel dwells from the sample after the
  // transfer edge; channel c shows exp_seq[c].
  task automatic watch(input int nch);
    int highs;
    int peak;
    logic [NOUT:0] mask;
    logic ok_idx, ok_busy, ok_oth, ok_low, ok_done;
    logic exp_done;
    for (int c = 0; c < nch; c++) begin
      highs = 0;
      peak  = 0;
      ok_idx = 1; ok_busy = 1; ok_oth = 1;
      ok_low = 1; ok_done = 1;
      mask = '0;
      mask[exp_seq[c]] = 1'b1;
      for (int k = 0; k < 129; k++) begin
        if (c > 0 || k > 0) step();
        exp_done = (k == 0 && c > 0) ? done_after[c-1] : 1'b0;
        if (active_idx !== 6'(exp_seq[c])) ok_idx = 0;
        if (busy !== 1'b1) ok_busy = 0;
        if ((out & ~mask) !== '0) ok_oth = 0;
        if ((k <= 4 || k == 128) && out !== '0) ok_low = 0;
        if (sweep_done !== exp_done) ok_done = 0;
        if (out[exp_seq[c]] === 1'b1) begin
          highs++;
          if (k >= 62 && k <= 69) peak++;
        end
      end
      chk($sformatf("idx_c%0d", c), 64'(ok_idx), 64'd1);
      chk($sformatf("busy_c%0d", c), 64'(ok_busy), 64'd1);
      chk($sformatf("other_bits_c%0d", c), 64'(ok_oth), 64'd1);
      chk($sformatf("low_ends_c%0d", c), 64'(ok_low), 64'd1);
      chk($sformatf("done_c%0d", c), 64'(ok_done), 64'd1);
      chk($sformatf("highs_c%0d", c), 64'(highs), 64'd60);
      chk($sformatf("peak_c%0d", c), 64'(peak), 64'd7);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_mode  = 2'd0;
    cif.cfg_start = 6'd0;
    cif.cfg_end   = 6'd0;
    #3;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idx", 64'(active_idx), 64'd0);
    chk("rst_done", 64'(sweep_done), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_ready", 64'(cif.cfg_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // oneshot 3..5
    exp_seq    = '{3, 4, 5, 0, 0, 0, 0, 0};
    done_after = '{0, 0, 1, 0, 0, 0, 0, 0};
    offer(2'd1, 6'd3, 6'd5);
    watch(3);
    step();
    chk("os_done", 64'(sweep_done), 64'd1);
    chk("os_busy", 64'(busy), 64'd0);
    chk("os_ready", 64'(cif.cfg_ready), 64'd1);
    chk("os_idx_hold", 64'(active_idx), 64'd5);
    step();
    chk("os_done_end", 64'(sweep_done), 64'd0);

    // loop 7 -> 6, then abort in ramp down
    exp_seq    = '{7, 6, 7, 6, 0, 0, 0, 0};
    done_after = '{0, 1, 0, 1, 0, 0, 0, 0};
    offer(2'd2, 6'd7, 6'd6);
    watch(4);
    step();
    chk("lp_done", 64'(sweep_done), 64'd1);
    chk("lp_idx", 64'(active_idx), 64'd7);
    repeat (69) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_out", 64'(out), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_done", 64'(sweep_done), 64'd0);
    chk("ab_ready", 64'(cif.cfg_ready), 64'd1);
    step();
    chk("ab_done2", 64'(sweep_done), 64'd0);

    // pingpong 2..4
    exp_seq    = '{2, 3, 4, 3, 2, 3, 0, 0};
    done_after = '{0, 0, 1, 0, 1, 0, 0, 0};
    offer(2'd3, 6'd2, 6'd4);
    watch(6);
    step();
    chk("pp_idx", 64'(active_idx), 64'd4);
    chk("pp_done", 64'(sweep_done), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // pingpong single channel
    exp_seq    = '{9, 9, 9, 0, 0, 0, 0, 0};
    done_after = '{1, 1, 1, 0, 0, 0, 0, 0};
    offer(2'd3, 6'd9, 6'd9);
    watch(3);
    step();
    chk("pp9_done", 64'(sweep_done), 64'd1);
    chk("pp9_idx", 64'(active_idx), 64'd9);
    chk("pp9_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // rejected and ignored configurations
    offer(2'd1, 6'd0, 6'd56);
    chk("err_end", 64'(cfg_err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    step();
    chk("err_once", 64'(cfg_err), 64'd0);
    chk("err_busy2", 64'(busy), 64'd0);
    offer(2'd2, 6'd60, 6'd3);
    chk("err_start", 64'(cfg_err), 64'd1);
    step();
    offer(2'd0, 6'd4, 6'd5);
    chk("off_err", 64'(cfg_err), 64'd0);
    chk("off_busy", 64'(busy), 64'd0);
    chk("off_idx", 64'(active_idx), 64'd9);
    offer(2'd1, 6'd0, 6'd0);
    chk("bz_busy", 64'(busy), 64'd1);
    cif.cfg_mode  = 2'd2;
    cif.cfg_start = 6'd10;
    cif.cfg_end   = 6'd12;
    cif.cfg_valid = 1'b1;
    chk("bz_ready", 64'(cif.cfg_ready), 64'd0);
    repeat (3) step();
    cif.cfg_valid = 1'b0;
    chk("bz_idx", 64'(active_idx), 64'd0);
    chk("bz_busy2", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    chk("bz_abort", 64'(busy), 64'd0);
    offer(2'd1, 6'd8, 6'd8);
    abort = 1'b0;
    chk("ab_idle_busy", 64'(busy), 64'd1);
    chk("ab_idle_idx", 64'(active_idx), 64'd8);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // async reset mid ramp
    offer(2'd1, 6'd20, 6'd21);
    repeat (10) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out", 64'(out), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_idx", 64'(active_idx), 64'd0);
    chk("ar_ready", 64'(cif.cfg_ready), 64'd1);
    chk("ar_done", 64'(sweep_done), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    exp_seq    = '{1, 0, 0, 0, 0, 0, 0, 0};
    done_after = '{1, 0, 0, 0, 0, 0, 0, 0};
    offer(2'd1, 6'd1, 6'd1);
    watch(1);
    step();
    chk("ar_os_done", 64'(sweep_done), 64'd1);
    chk("ar_os_busy", 64'(busy), 64'd0);
    chk("ar_os_idx", 64'(active_idx), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_glow_sched.md
Name: led_glow_sched

Overview:
- Sequencer that drives a single PWM glow engine across a bank of LED outputs.
- Accepts a sweep configuration (channel range, mode) over a valid/ready handshake.
- Ramps brightness up then down on one channel at a time, then advances to the next channel.
- Sits between a board-level controller or register file and the LED pins; replaces the free-running counter-driven glow.

Parameters:
- NOUT, 55: highest output index; out is NOUT+1 bits wide; NOUT must be ≤63.
- STEP_DIV, 20: log2 of clock cycles per brightness step.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  block can accept configuration
- cfg_mode  in  2  0=OFF, 1=ONESHOT, 2=LOOP, 3=PINGPONG
- cfg_start  in  6  first channel index
- cfg_end  in  6  last channel index
- abort  in  1  stop sweep immediately
- out  out  NOUT+1  LED drive, registered
- busy  out  1  sweep in progress
- active_idx  out  6  channel currently glowing
- sweep_done  out  1  one-cycle pulse at end of each pass
- cfg_err  out  1  one-cycle pulse, configuration rejected

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out=0, busy=0, active_idx=0, sweep_done=0, cfg_err=0, cfg_ready=1.
  - level=0, prescaler=0, PWM accumulator=0.
- States: IDLE, RAMP_UP, RAMP_DOWN, ADVANCE.
- Handshake:
  - cfg_ready=1 only in IDLE.
  - Transfer occurs on a clk edge with cfg_valid&&cfg_ready.
  - Inputs are sampled only at transfer.
- On transfer:
  - If cfg_start>NOUT or cfg_end>NOUT: pulse cfg_err next cycle, stay IDLE.
  - Else if mode=OFF: stay IDLE, no pulse.
  - Else: latch start, end, mode; set dir=(start<=end ? +1 : -1); active_idx=start; level=0; prescaler=0; go RAMP_UP.
- busy=1 in RAMP_UP, RAMP_DOWN and ADVANCE.
- Prescaler:
  - STEP_DIV-bit counter, increments every cycle in RAMP_UP/RAMP_DOWN; cleared in IDLE and ADVANCE.
  - tick = prescaler all-ones.
  - The first tick occurs 2^STEP_DIV cycles after entering RAMP_UP.
- RAMP_UP on tick: if level==15, go RAMP_DOWN (level held); else level+1.
- RAMP_DOWN on tick: if level==0, go ADVANCE; else level-1.
- Per-channel dwell: exactly 32 ticks (32·2^STEP_DIV cycles) plus 1 ADVANCE cycle.
- ADVANCE (one cycle, out all zero):
  - active_idx≠end: active_idx+=dir, go RAMP_UP.
  - active_idx==end, ONESHOT: pulse sweep_done, go IDLE.
  - active_idx==end, LOOP: pulse sweep_done, active_idx=start, go RAMP_UP.
  - active_idx==end, PINGPONG: pulse sweep_done, swap start/end, negate dir, go RAMP_UP. If start≠end, active_idx steps by the new dir; if start==end, active_idx is unchanged.
  - On every re-entry to RAMP_UP: level=0.
- PWM:
  - 5-bit accumulator; acc <= {1'b0,acc[3:0]} + level every cycle in RAMP states.
  - pwm = acc[4].
  - Duty is level/16: level 0 never high; level 15 gives 15 highs per 16 cycles.
- out register:
  - out[active_idx] = pwm, registered one cycle after the accumulator.
  - All other bits are 0.
  - In IDLE and ADVANCE, out=0.
  - At most one bit of out is ever 1.
- abort:
  - Has priority over all transitions.
  - Next edge: state=IDLE, out=0, level=0, busy=0, no sweep_done.
  - Ignored in IDLE.
- Simultaneous abort and cfg_valid in IDLE: the transfer proceeds (abort has no effect in IDLE).
- Reset mid-sweep: all state returns to reset values immediately; no pulses are generated.
- active_idx holds its last value in IDLE; it is reset to 0 only by rst_n.

Test Plan:
1. STEP_DIV=2, cfg {ONESHOT, start=3, end=5} -> active_idx 3,4,5, 129 cycles each. sweep_done pulses once at the ADVANCE for idx 5, then IDLE with cfg_ready=1. Only out[3..5] ever toggle.
2. STEP_DIV=2, level held at 15 during RAMP_UP -> out[idx] high exactly 15 of any 16 consecutive cycles. At level 0, out is stuck low.
3. LOOP {start=7, end=6} -> idx sequence 7,6,7,6…. sweep_done pulses after each 6. abort mid-RAMP_DOWN -> out=0 and busy=0 next cycle, with no sweep_done.
4. PINGPONG {2,4} -> idx 2,3,4,3,2,3,…. sweep_done pulses at each endpoint. PINGPONG {9,9} -> idx stays 9.
5. cfg_end=NOUT+1 -> cfg_err pulses once, busy stays 0. mode=OFF -> no pulse, busy stays 0. cfg_valid while busy -> ignored (cfg_ready=0).
6. rst_n asserted asynchronously mid-cycle during RAMP_UP -> out=0, busy=0, active_idx=0 before the next clk edge. Release, then a new cfg is accepted normally.
